regbank_mp: RTL

Parametrised multi-port register bank for the nemesys core, the successor to the single-write-port bank. It provides two combinational read ports, two write ports with fixed priority, an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard with a reserve handshake. It sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/regbank_mp_pkg.sv | 14 +
 rtl/regbank_mp_if.sv | 47 ++++
 rtl/regbank_mp_reg_scoreboard.sv | 99 +++++++++
 rtl/regbank_mp.sv | 83 ++++++++
 4 files changed

// File: rtl/regbank_mp_pkg.sv
// Shared definitions for the nemesys multi-port register bank.
// Holds the default bank geometry and the address legality helper used by the bank and its scoreboard.
package regbank_mp_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_SEL  = 5;

    // An address takes writes and reservations only inside the bank and, with a hardwired r0, never r0.
    function automatic bit addr_ok(input int addr, input int num_regs, input bit zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Bus bundle between issue/writeback and the register bank.
// The master drives addresses, writes and reservations; the slave is the bank.
interface regbank_mp_if
    import regbank_mp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REG_SEL = DEF_REG_SEL
);

    logic [REG_SEL-1:0] rd_addr_a;
    logic [REG_SEL-1:0] rd_addr_b;
    logic [WIDTH-1:0]   rd_data_a;
    logic [WIDTH-1:0]   rd_data_b;
    logic               rd_busy_a;
    logic               rd_busy_b;

    logic               wr0_en;
    logic [REG_SEL-1:0] wr0_addr;
    logic [WIDTH-1:0]   wr0_data;
    logic               wr1_en;
    logic [REG_SEL-1:0] wr1_addr;
    logic [WIDTH-1:0]   wr1_data;

    logic               rsv_en;
    logic [REG_SEL-1:0] rsv_addr;
    logic               rsv_ok;
    logic [REG_SEL:0]   busy_cnt;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        input  rsv_ok, busy_cnt
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        output rsv_ok, busy_cnt
    );

endinterface

// File: rtl/regbank_mp_reg_scoreboard.sv
// Per-register busy scoreboard: reserve handshake, busy read-out and registered busy population.
// Write enables arriving here are already arbitrated and legal, so they never collide with each other.
module reg_scoreboard
    import regbank_mp_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_SEL  = DEF_REG_SEL,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w0_en,
    input  logic [REG_SEL-1:0] w0_addr,
    input  logic               w1_en,
    input  logic [REG_SEL-1:0] w1_addr,
    input  logic               rsv_en,
    input  logic [REG_SEL-1:0] rsv_addr,
    input  logic [REG_SEL-1:0] addr_a,
    input  logic [REG_SEL-1:0] addr_b,
    output logic               busy_a,
    output logic               busy_b,
    output logic               rsv_ok,
    output logic [REG_SEL:0]   busy_cnt
);

    localparam int CW = REG_SEL + 1;

    logic [NUM_REGS-1:0] busy = '0;
    logic [CW-1:0]       cnt  = '0;
    logic [NUM_REGS-1:0] busy_next;
    logic [CW-1:0]       cnt_next;

    logic busy_at_rsv;
    logic busy_at_w0;
    logic busy_at_w1;
    logic raw_a;
    logic raw_b;
    logic grant;
    logic set_new;
    logic clr0;
    logic clr1;
    logic hit_a;
    logic hit_b;

    // Out-of-range addresses match no register and so look permanently idle.
    always_comb begin
        busy_at_rsv = 1'b0;
        busy_at_w0  = 1'b0;
        busy_at_w1  = 1'b0;
        raw_a       = 1'b0;
        raw_b       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsv_addr == REG_SEL'(i)) busy_at_rsv = busy[i];
            if (w0_addr  == REG_SEL'(i)) busy_at_w0  = busy[i];
            if (w1_addr  == REG_SEL'(i)) busy_at_w1  = busy[i];
            if (addr_a   == REG_SEL'(i)) raw_a       = busy[i];
            if (addr_b   == REG_SEL'(i)) raw_b       = busy[i];
        end
    end

    always_comb begin
        hit_a   = (w0_en && (w0_addr == addr_a)) || (w1_en && (w1_addr == addr_a));
        hit_b   = (w0_en && (w0_addr == addr_b)) || (w1_en && (w1_addr == addr_b));
        busy_a  = raw_a && !(BYPASS && hit_a);
        busy_b  = raw_b && !(BYPASS && hit_b);
        rsv_ok  = !busy_at_rsv
                  || (w0_en && (w0_addr == rsv_addr))
                  || (w1_en && (w1_addr == rsv_addr));
        grant   = rsv_en && rsv_ok && addr_ok(32'(rsv_addr), NUM_REGS, ZERO_REG);
        set_new = grant && !busy_at_rsv;
        // A write that lands on the register being reserved leaves it busy, so it does not count down.
        clr0    = w0_en && busy_at_w0 && !(grant && (rsv_addr == w0_addr));
        clr1    = w1_en && busy_at_w1 && !(grant && (rsv_addr == w1_addr));
        cnt_next = cnt + CW'(set_new) - CW'(clr0) - CW'(clr1);
    end

    always_comb begin
        busy_next = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w0_en && (w0_addr == REG_SEL'(i))) busy_next[i] = 1'b0;
            if (w1_en && (w1_addr == REG_SEL'(i))) busy_next[i] = 1'b0;
            if (grant && (rsv_addr == REG_SEL'(i))) busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_next;
            cnt  <= cnt_next;
        end
    end

    assign busy_cnt = cnt;

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank: two combinational read ports, two prioritised write ports,
// optional hardwired r0 and write-to-read bypass, with busy tracking delegated to reg_scoreboard.
module regbank_mp
    import regbank_mp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_SEL  = DEF_REG_SEL,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic        clk,
    input logic        reset,
    regbank_mp_if.slave bus
);

    logic [WIDTH-1:0]   regs [NUM_REGS] = '{default: '0};
    logic               w0_en;
    logic               w1_en;
    logic [REG_SEL-1:0] raddr [2];
    logic [WIDTH-1:0]   rdata [2];

    // Port 1 wins a same-address collision, so port 0 is squashed rather than merged.
    always_comb begin
        w1_en = bus.wr1_en && addr_ok(32'(bus.wr1_addr), NUM_REGS, ZERO_REG);
        w0_en = bus.wr0_en && addr_ok(32'(bus.wr0_addr), NUM_REGS, ZERO_REG)
                && !(bus.wr1_en && (bus.wr1_addr == bus.wr0_addr));
    end

    assign raddr[0] = bus.rd_addr_a;
    assign raddr[1] = bus.rd_addr_b;

    // Bypass checks port 1 last so its data overrides port 0 on the same address.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((raddr[p] == REG_SEL'(i)) && !(ZERO_REG && (i == 0))) rdata[p] = regs[i];
            end
            if (BYPASS) begin
                if (w0_en && (bus.wr0_addr == raddr[p])) rdata[p] = bus.wr0_data;
                if (w1_en && (bus.wr1_addr == raddr[p])) rdata[p] = bus.wr1_data;
            end
        end
    end

    assign bus.rd_data_a = rdata[0];
    assign bus.rd_data_b = rdata[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w1_en && (bus.wr1_addr == REG_SEL'(i))) regs[i] <= bus.wr1_data;
                else if (w0_en && (bus.wr0_addr == REG_SEL'(i))) regs[i] <= bus.wr0_data;
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_SEL  (REG_SEL),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .w0_en    (w0_en),
        .w0_addr  (bus.wr0_addr),
        .w1_en    (w1_en),
        .w1_addr  (bus.wr1_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .addr_a   (bus.rd_addr_a),
        .addr_b   (bus.rd_addr_b),
        .busy_a   (bus.rd_busy_a),
        .busy_b   (bus.rd_busy_b),
        .rsv_ok   (bus.rsv_ok),
        .busy_cnt (bus.busy_cnt)
    );

endmodule
